sram_ctrl: RTL and testbench

SRAM_CTRL -- requirements
Module: sram_ctrl

---
 rtl/sram_ctrl_pkg.sv | 7 +
 rtl/sram_ctrl.sv | 87 ++++++++
 tb/tb_sram_ctrl.sv | 122 ++++++++++++
 3 files changed

// File: rtl/sram_ctrl_pkg.sv
// sram_ctrl_pkg: shared widths, default SRAM base address and FSM encoding for sram_ctrl.
package sram_ctrl_pkg;
  localparam int ADDRESS_LEN = 32;
  localparam int REGISTER_LEN = 32;
  localparam int unsigned BASE_ADDR_DEFAULT = 1024;
  typedef enum logic [2:0] {IDLE, LOW, HIGH, WAIT, DONE} state_e;
endpackage

// File: rtl/sram_ctrl.sv
// sram_ctrl: splits 32-bit CPU accesses into two 16-bit SRAM half-accesses and stalls the pipeline meanwhile.
module sram_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 3,
  parameter logic [ADDRESS_LEN-1:0] BASE_ADDR = BASE_ADDR_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic                    rd_en,
  input  logic [ADDRESS_LEN-1:0]  address,
  input  logic [REGISTER_LEN-1:0] write_data,
  output logic [REGISTER_LEN-1:0] read_data,
  output logic                    ready,
  output logic [17:0]             sram_addr,
  output logic [15:0]             sram_dq_out,
  input  logic [15:0]             sram_dq_in,
  output logic                    sram_dq_oe,
  output logic                    sram_we_n
);
  localparam int CW = (WAIT_CYCLES < 2) ? 1 : $clog2(WAIT_CYCLES);
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [16:0] idx_q, idx_d;
  logic [REGISTER_LEN-1:0] data_q, data_d, rd_data_q, rd_data_d;
  logic wr_q, wr_d;
  logic req, active, drive;
  assign req = rd_en | wr_en;
  assign active = (state_q == LOW) || (state_q == HIGH);
  assign drive = active && wr_q;
  assign read_data = rd_data_q;
  assign ready = (state_q == DONE) || (state_q == IDLE && !req);
  assign sram_addr = active ? {idx_q, state_q == HIGH} : '0;
  assign sram_dq_out = drive ? (state_q == HIGH ? data_q[31:16] : data_q[15:0]) : '0;
  assign sram_dq_oe = drive;
  assign sram_we_n = !drive;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    idx_d = idx_q;
    data_d = data_q;
    wr_d = wr_q;
    rd_data_d = rd_data_q;
    unique case (state_q)
      IDLE: if (req) begin
        state_d = LOW;
        idx_d = 17'((address - BASE_ADDR) >> 2);
        data_d = write_data;
        wr_d = wr_en;
      end
      LOW: begin
        state_d = HIGH;
        if (!wr_q) rd_data_d[15:0] = sram_dq_in;
      end
      HIGH: begin
        state_d = (WAIT_CYCLES == 0) ? DONE : WAIT;
        cnt_d = CW'(WAIT_CYCLES - 1);
        if (!wr_q) rd_data_d[31:16] = sram_dq_in;
      end
      // counter was preloaded with WAIT_CYCLES-1, so WAIT lasts exactly WAIT_CYCLES cycles
      WAIT: begin
        state_d = (cnt_q == '0) ? DONE : WAIT;
        cnt_d = (cnt_q == '0) ? '0 : cnt_q - 1'b1;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      idx_q <= '0;
      data_q <= '0;
      wr_q <= 1'b0;
      rd_data_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      data_q <= data_d;
      wr_q <= wr_d;
      rd_data_q <= rd_data_d;
    end
  end
endmodule

// File: tb/tb_sram_ctrl.sv
// tb_sram_ctrl: directed checks of sram_ctrl at WAIT_CYCLES=3 and a WAIT_CYCLES=0 build against a 16-bit SRAM model.
module tb_sram_ctrl;
  logic clk = 1'b0, rst = 1'b1, wr_en = 1'b0, rd_en = 1'b0, wr0 = 1'b0, rd0 = 1'b0;
  logic [31:0] address = '0, write_data = '0, read_data, read_data0;
  logic ready, ready0, oe, oe0, we_n, we_n0;
  logic [17:0] sram_addr, sram_addr0;
  logic [15:0] dq_out, dq_out0, dq_in, dq_in0;
  logic [15:0] mem [64];
  int total = 0, fails = 0;
  always #5 clk = ~clk;
  sram_ctrl u_dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .address(address), .write_data(write_data),
    .read_data(read_data), .ready(ready), .sram_addr(sram_addr), .sram_dq_out(dq_out),
    .sram_dq_in(dq_in), .sram_dq_oe(oe), .sram_we_n(we_n)
  );
  sram_ctrl #(.WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rst(rst), .wr_en(wr0), .rd_en(rd0), .address(address), .write_data(write_data),
    .read_data(read_data0), .ready(ready0), .sram_addr(sram_addr0), .sram_dq_out(dq_out0),
    .sram_dq_in(dq_in0), .sram_dq_oe(oe0), .sram_we_n(we_n0)
  );
  assign dq_in = mem[sram_addr[5:0]];
  assign dq_in0 = mem[sram_addr0[5:0]];
  always @(posedge clk) if (!we_n) mem[sram_addr[5:0]] <= dq_out;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic nxt();
    @(negedge clk);
    #1;
  endtask
  initial begin
    nxt();
    nxt();
    rst = 1'b0;
    nxt();
    chk("idle_ready", ready, 1);
    chk("idle_we_n", we_n, 1);
    chk("idle_oe", oe, 0);
    chk("idle_rdata", read_data, 0);
    chk("idle_addr", sram_addr, 0);
    wr_en = 1'b1; address = 32'd1032; write_data = 32'hDEADBEEF;
    #1 chk("w_c0_ready", ready, 0);
    for (int c = 1; c <= 6; c++) begin
      nxt();
      if (c == 1) begin address = 32'd0; write_data = 32'h0; end
      chk($sformatf("w_c%0d_ready", c), ready, 32'(c == 6));
      chk($sformatf("w_c%0d_we_n", c), we_n, 32'(c > 2));
      chk($sformatf("w_c%0d_oe", c), oe, 32'(c <= 2));
      if (c == 1) begin chk("w_c1_addr", sram_addr, 4); chk("w_c1_dq", dq_out, 16'hBEEF); end
      if (c == 2) begin chk("w_c2_addr", sram_addr, 5); chk("w_c2_dq", dq_out, 16'hDEAD); end
    end
    wr_en = 1'b0;
    chk("w_rdata_kept", read_data, 0);
    chk("w_mem4", mem[4], 16'hBEEF);
    chk("w_mem5", mem[5], 16'hDEAD);
    nxt();
    rd_en = 1'b1; address = 32'd1032;
    #1 chk("r_c0_ready", ready, 0);
    for (int c = 1; c <= 6; c++) begin
      nxt();
      if (c == 1) address = 32'd1036;
      chk($sformatf("r_c%0d_ready", c), ready, 32'(c == 6));
      chk($sformatf("r_c%0d_we_n", c), we_n, 1);
    end
    chk("r_rdata", read_data, 32'hDEADBEEF);
    rd_en = 1'b0;
    nxt();
    chk("r_rdata_hold", read_data, 32'hDEADBEEF);
    rd_en = 1'b1; wr_en = 1'b1; address = 32'd1036; write_data = 32'h12345678;
    for (int c = 1; c <= 6; c++) begin
      nxt();
      if (c == 1) begin chk("b_c1_addr", sram_addr, 6); chk("b_c1_dq", dq_out, 16'h5678); chk("b_c1_we_n", we_n, 0); end
      if (c == 2) begin chk("b_c2_addr", sram_addr, 7); chk("b_c2_dq", dq_out, 16'h1234); end
    end
    chk("b_ready", ready, 1);
    chk("b_rdata", read_data, 32'hDEADBEEF);
    rd_en = 1'b0; wr_en = 1'b0;
    chk("b_mem6", mem[6], 16'h5678);
    chk("b_mem7", mem[7], 16'h1234);
    nxt();
    wr_en = 1'b1; address = 32'd1040; write_data = 32'hCAFEF00D;
    for (int c = 1; c <= 3; c++) nxt();
    chk("rs_c3_ready", ready, 0);
    rst = 1'b1; wr_en = 1'b0;
    nxt();
    rst = 1'b0;
    #1;
    chk("rs_ready", ready, 1);
    chk("rs_we_n", we_n, 1);
    chk("rs_oe", oe, 0);
    chk("rs_addr", sram_addr, 0);
    chk("rs_rdata", read_data, 0);
    nxt();
    chk("rs_idle_ready", ready, 1);
    rd_en = 1'b1; address = 32'd1032;
    #1 chk("bb_c0_ready", ready, 0);
    for (int c = 1; c <= 13; c++) begin
      nxt();
      chk($sformatf("bb_c%0d_ready", c), ready, 32'(c == 6 || c == 13));
      if (c == 6) chk("bb_c6_rdata", read_data, 32'hDEADBEEF);
      if (c == 8) chk("bb_c8_addr", sram_addr, 4);
    end
    rd_en = 1'b0;
    nxt();
    rd0 = 1'b1; address = 32'd1032;
    #1 chk("z_c0_ready", ready0, 0);
    for (int c = 1; c <= 3; c++) begin
      nxt();
      chk($sformatf("z_c%0d_ready", c), ready0, 32'(c == 3));
    end
    chk("z_rdata", read_data0, 32'hDEADBEEF);
    rd0 = 1'b0;
    nxt();
    chk("z_idle_ready", ready0, 1);
    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule
